note_detector: RTL and testbench

- Receive side of the piano tone path: measures the period of an incoming square-wave tone (the piano's FREQ line or an external pin) and decodes it to one of the eight notes C4..C5.
- Output uses the same one-hot switch encoding the piano consumes (bit0 = C4 ... bit7 = C5), so a played tone can be looped back or displayed on LEDs/7-seg.
- Runs on the 100 MHz board clock.

---
 rtl/piano_pkg.sv | 39 +++
 rtl/note_detector_if.sv | 26 ++
 rtl/note_detector_edge_sync.sv | 31 +++
 rtl/note_detector.sv | 154 +++++++++++++++
 tb/tb_note_detector.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone path: note indices, nominal tone
// periods at the 100 MHz board clock, and the one-hot switch encoding.
package piano_pkg;

  localparam int CLK_HZ = 100_000_000;

  typedef enum logic [2:0] {
    NOTE_C4 = 3'd0,
    NOTE_D4 = 3'd1,
    NOTE_E4 = 3'd2,
    NOTE_F4 = 3'd3,
    NOTE_G4 = 3'd4,
    NOTE_A4 = 3'd5,
    NOTE_B4 = 3'd6,
    NOTE_C5 = 3'd7
  } note_t;

  typedef logic [2:0]        note_idx_t;
  typedef logic [7:0]        note_oh_t;
  typedef logic [31:0]       period_t;
  typedef period_t [7:0]     period_table_t;

  // Index 7 (C5) is the leftmost element of the packed table.
  localparam period_table_t NOMINAL_PERIODS = {
    32'd191113, 32'd202478, 32'd227273, 32'd255102,
    32'd286344, 32'd303370, 32'd340530, 32'd382225
  };

  // Switch encoding shared with the tone generator: bit0 = C4 ... bit7 = C5.
  function automatic note_oh_t note_onehot(input note_idx_t idx);
    return note_oh_t'(1) << idx;
  endfunction

  // Tone period in board-clock cycles for a frequency in Hz.
  function automatic period_t period_cycles(input int hz);
    return period_t'(CLK_HZ / hz);
  endfunction

endpackage

// File: rtl/note_detector_if.sv
// Detector bus: tone input plus decoded-note outputs. The detector side
// uses the master modport, consumers (LEDs, loopback, bench) the slave one.
interface note_detector_if
  import piano_pkg::*;
#(
  parameter int CNT_W = 20
);

  logic             FREQ_IN;
  note_idx_t        NOTE;
  note_oh_t         NOTE_OH;
  logic             NOTE_VALID;
  logic             NEW_NOTE;
  logic [CNT_W-1:0] PERIOD;

  modport master (
    input  FREQ_IN,
    output NOTE, NOTE_OH, NOTE_VALID, NEW_NOTE, PERIOD
  );

  modport slave (
    output FREQ_IN,
    input  NOTE, NOTE_OH, NOTE_VALID, NEW_NOTE, PERIOD
  );

endinterface

// File: rtl/note_detector_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse is high for one cycle, three clocks after the input rises.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_p
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Synchronize the input, then compare against its delayed copy.
  // NOTE: sequential logic uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, as real hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      sync1  <= async_in;
      sync2  <= sync1;
      sync3  <= sync2;
      rise_p <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square-wave tone and decodes it to
// one of the eight notes C4..C5, requiring STABLE_CNT agreeing periods.
module note_detector
  import piano_pkg::*;
#(
  parameter int            CNT_W      = 20,
  parameter int            MAX_PERIOD = 500000,
  parameter int            MIN_PERIOD = 150000,
  parameter int            TOL        = 4000,
  parameter int            STABLE_CNT = 2,
  parameter period_table_t NOMINAL    = NOMINAL_PERIODS
) (
  input  logic           CLK,
  input  logic           RESET,
  note_detector_if.master bus
);

  localparam logic [1:0] WAIT_EDGE = 2'd0;
  localparam logic [1:0] COUNT     = 2'd1;
  localparam logic [1:0] CLASSIFY  = 2'd2;

  localparam int               SW         = $clog2(STABLE_CNT + 1);
  localparam logic [SW-1:0]    STABLE_MAX = SW'(STABLE_CNT);
  localparam logic [CNT_W-1:0] MAX_P      = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TOL_P      = CNT_W'(TOL);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cmp_q;
  logic [SW-1:0]    stable;
  logic [SW-1:0]    stable_next;
  note_idx_t        last_idx;
  note_idx_t        note_q;
  logic             valid_q;
  logic             new_note_q;
  logic             rise_p;
  logic             match;
  note_idx_t        match_idx;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  edge_sync u_edge_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (bus.FREQ_IN),
    .rise_p   (rise_p)
  );

  // Find the nominal period whose tolerance window holds the latched period;
  // windows never overlap, so at most one entry can hit.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (cmp_q >= MIN_P && abs_diff(cmp_q, NOMINAL[i][CNT_W-1:0]) <= TOL_P) begin
        match     = 1'b1;
        match_idx = note_idx_t'(i);
      end
    end
  end

  // Consecutive matches on the same note build confidence, saturating.
  always_comb begin
    if (stable != '0 && match_idx == last_idx) begin
      stable_next = (stable == STABLE_MAX) ? stable : stable + SW'(1);
    end else begin
      stable_next = SW'(1);
    end
  end

  // Period measurement FSM plus the registered note outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= WAIT_EDGE;
      cnt        <= '0;
      period_q   <= '0;
      cmp_q      <= '0;
      stable     <= '0;
      last_idx   <= '0;
      note_q     <= '0;
      valid_q    <= 1'b0;
      new_note_q <= 1'b0;
    end else begin
      new_note_q <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          if (rise_p) begin
            cnt   <= CNT_W'(1);
            state <= COUNT;
          end else begin
            cnt <= '0;
          end
        end
        COUNT: begin
          if (cnt == MAX_P) begin
            // Silence: drop the note but keep its index; a coincident edge
            // still opens a fresh measurement.
            valid_q <= 1'b0;
            stable  <= '0;
            if (rise_p) begin
              cnt   <= CNT_W'(1);
              state <= COUNT;
            end else begin
              cnt   <= '0;
              state <= WAIT_EDGE;
            end
          end else if (rise_p) begin
            period_q <= cnt;
            cmp_q    <= cnt;
            cnt      <= CNT_W'(1);
            state    <= CLASSIFY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLASSIFY: begin
          // Keep counting the next period while the last one is judged.
          cnt   <= cnt + 1'b1;
          state <= COUNT;
          if (match) begin
            last_idx <= match_idx;
            stable   <= stable_next;
            if (stable_next == STABLE_MAX) begin
              note_q     <= match_idx;
              valid_q    <= 1'b1;
              new_note_q <= !valid_q || (note_q != match_idx);
            end
          end else begin
            stable  <= '0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          cnt   <= '0;
          state <= WAIT_EDGE;
        end
      endcase
    end
  end

  assign bus.NOTE       = note_q;
  assign bus.NOTE_VALID = valid_q;
  assign bus.NOTE_OH    = valid_q ? note_onehot(note_q) : '0;
  assign bus.NEW_NOTE   = new_note_q;
  assign bus.PERIOD     = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector. Tone periods and thresholds are scaled down by
// 1000 (nominal table rounded) so each scenario stays a few thousand cycles.
module tb_note_detector;
  import piano_pkg::*;

  localparam int CNT_W  = 20;
  localparam int MAX_P  = 500;
  localparam int MIN_P  = 150;
  localparam int TOL_P  = 4;
  localparam int STABLE = 2;
  localparam period_table_t TB_NOMINAL = {
    32'd191, 32'd202, 32'd227, 32'd255, 32'd286, 32'd303, 32'd341, 32'd382
  };

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  note_detector_if #(.CNT_W(CNT_W)) bus ();

  note_detector #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAX_P),
    .MIN_PERIOD (MIN_P),
    .TOL        (TOL_P),
    .STABLE_CNT (STABLE),
    .NOMINAL    (TB_NOMINAL)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic       valid;
    logic [2:0] note;
    logic       new_note;
    logic       chk_period;
    int         period;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   pulses     = 0;
  int   last_p     = 0;
  int   last_rise  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: each expectation is due five clocks after its FREQ_IN edge.
  always @(negedge CLK) begin : monitor
    exp_t       e;
    logic [7:0] exp_oh;
    if (bus.NEW_NOTE === 1'b1) pulses++;
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      e      = sb.pop_front();
      exp_oh = e.valid ? (8'd1 << e.note) : 8'd0;
      compared++;
      if (bus.NOTE_VALID !== e.valid) begin
        mismatched++;
        $display("FAIL %s NOTE_VALID: got %b want %b", e.name, bus.NOTE_VALID, e.valid);
      end
      compared++;
      if (bus.NOTE_OH !== exp_oh) begin
        mismatched++;
        $display("FAIL %s NOTE_OH: got %b want %b", e.name, bus.NOTE_OH, exp_oh);
      end
      compared++;
      if (bus.NEW_NOTE !== e.new_note) begin
        mismatched++;
        $display("FAIL %s NEW_NOTE: got %b want %b", e.name, bus.NEW_NOTE, e.new_note);
      end
      if (e.valid) begin
        compared++;
        if (bus.NOTE !== e.note) begin
          mismatched++;
          $display("FAIL %s NOTE: got %0d want %0d", e.name, bus.NOTE, e.note);
        end
      end
      if (e.chk_period) begin
        compared++;
        if (bus.PERIOD !== CNT_W'(e.period)) begin
          mismatched++;
          $display("FAIL %s PERIOD: got %0d want %0d", e.name, bus.PERIOD, e.period);
        end
      end
    end
  end

  // Drive one rising edge (called at a negedge), queue what the DUT must
  // show once that edge is classified, then hold for `hold` cycles.
  task automatic edge_then(input int hold, input logic ev, input logic [2:0] en,
                           input logic enew, input logic cp, input string name);
    exp_t e;
    e.due        = cyc + 5;
    e.valid      = ev;
    e.note       = en;
    e.new_note   = enew;
    e.chk_period = cp;
    e.period     = last_p;
    e.name       = name;
    sb.push_back(e);
    last_rise   = cyc;
    bus.FREQ_IN = 1'b1;
    repeat (hold / 2) @(negedge CLK);
    bus.FREQ_IN = 1'b0;
    repeat (hold - hold / 2) @(negedge CLK);
    last_p = hold;
  endtask

  task automatic quiet(input string name);
    bus.FREQ_IN = 1'b0;
    repeat (MAX_P + 10) @(negedge CLK);
    compared++;
    if (bus.NOTE_VALID !== 1'b0) begin
      mismatched++;
      $display("FAIL %s quiet NOTE_VALID: got %b want 0", name, bus.NOTE_VALID);
    end
  endtask

  task automatic check_pulses(input int p0, input int want, input string name);
    compared++;
    if (pulses - p0 !== want) begin
      mismatched++;
      $display("FAIL %s pulse count: got %0d want %0d", name, pulses - p0, want);
    end
  endtask

  task automatic test_reset();
    int p0;
    RESET       = 1'b1;
    bus.FREQ_IN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge CLK);
      bus.FREQ_IN = ~bus.FREQ_IN;
    end
    bus.FREQ_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    p0    = pulses;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      compared++;
      if ({bus.NOTE, bus.NOTE_OH, bus.NOTE_VALID, bus.NEW_NOTE, bus.PERIOD} !== '0) begin
        mismatched++;
        $display("FAIL reset outputs cycle %0d: got note=%0d oh=%b v=%b nn=%b p=%0d want all 0",
                 i, bus.NOTE, bus.NOTE_OH, bus.NOTE_VALID, bus.NEW_NOTE, bus.PERIOD);
      end
    end
    check_pulses(p0, 0, "reset");
  endtask

  task automatic test_steady_a4();
    int p0 = pulses;
    edge_then(227, 1'b0, 3'd0, 1'b0, 1'b0, "a4_e1");
    edge_then(227, 1'b0, 3'd0, 1'b0, 1'b1, "a4_e2");
    edge_then(227, 1'b1, 3'd5, 1'b1, 1'b1, "a4_e3");
    for (int i = 0; i < 10; i++) edge_then(227, 1'b1, 3'd5, 1'b0, 1'b1, "a4_hold");
    check_pulses(p0, 1, "a4");
  endtask

  task automatic test_note_change();
    int p0;
    quiet("change");
    p0 = pulses;
    edge_then(385, 1'b0, 3'd0, 1'b0, 1'b0, "c4_e1");
    edge_then(385, 1'b0, 3'd0, 1'b0, 1'b1, "c4_e2");
    edge_then(385, 1'b1, 3'd0, 1'b1, 1'b1, "c4_e3");
    edge_then(187, 1'b1, 3'd0, 1'b0, 1'b1, "c4_e4");
    edge_then(187, 1'b1, 3'd0, 1'b0, 1'b1, "c5_first");
    edge_then(187, 1'b1, 3'd7, 1'b1, 1'b1, "c5_second");
    edge_then(196, 1'b1, 3'd7, 1'b0, 1'b1, "c5_third");
    edge_then(20,  1'b0, 3'd0, 1'b0, 1'b1, "c5_over_tol");
    check_pulses(p0, 2, "change");
  endtask

  task automatic test_glitch();
    int p0;
    quiet("glitch");
    p0 = pulses;
    edge_then(255, 1'b0, 3'd0, 1'b0, 1'b0, "g4_e1");
    edge_then(255, 1'b0, 3'd0, 1'b0, 1'b1, "g4_e2");
    edge_then(255, 1'b1, 3'd4, 1'b1, 1'b1, "g4_e3");
    edge_then(100, 1'b1, 3'd4, 1'b0, 1'b1, "g4_e4");
    edge_then(255, 1'b0, 3'd0, 1'b0, 1'b1, "g4_glitch");
    edge_then(255, 1'b0, 3'd0, 1'b0, 1'b1, "g4_good1");
    edge_then(255, 1'b1, 3'd4, 1'b1, 1'b1, "g4_good2");
    check_pulses(p0, 2, "glitch");
  endtask

  // The counter reaches MAX at the cycle an edge would yield period MAX, and
  // NOTE_VALID falls one clock later, like PERIOD does after a real edge.
  task automatic test_silence();
    int p0;
    int k;
    quiet("silence");
    p0 = pulses;
    edge_then(303, 1'b0, 3'd0, 1'b0, 1'b0, "e4_e1");
    edge_then(303, 1'b0, 3'd0, 1'b0, 1'b1, "e4_e2");
    edge_then(303, 1'b1, 3'd2, 1'b1, 1'b1, "e4_e3");
    edge_then(20,  1'b1, 3'd2, 1'b0, 1'b1, "e4_last");
    k = last_rise;
    while (cyc < k + 3 + MAX_P) @(negedge CLK);
    compared++;
    if (bus.NOTE_VALID !== 1'b1) begin
      mismatched++;
      $display("FAIL silence before timeout NOTE_VALID: got %b want 1", bus.NOTE_VALID);
    end
    @(negedge CLK);
    compared++;
    if (bus.NOTE_VALID !== 1'b0 || bus.NOTE_OH !== 8'd0) begin
      mismatched++;
      $display("FAIL silence timeout: got v=%b oh=%b want v=0 oh=0", bus.NOTE_VALID, bus.NOTE_OH);
    end
    compared++;
    if (bus.NOTE !== 3'd2) begin
      mismatched++;
      $display("FAIL silence NOTE hold: got %0d want 2", bus.NOTE);
    end
    edge_then(303, 1'b0, 3'd0, 1'b0, 1'b0, "e4_re1");
    edge_then(303, 1'b0, 3'd0, 1'b0, 1'b1, "e4_re2");
    edge_then(303, 1'b1, 3'd2, 1'b1, 1'b1, "e4_re3");
    check_pulses(p0, 2, "silence");
  endtask

  task automatic test_reset_mid();
    int p0;
    quiet("reset_mid");
    p0 = pulses;
    edge_then(341, 1'b0, 3'd0, 1'b0, 1'b0, "d4_e1");
    edge_then(341, 1'b0, 3'd0, 1'b0, 1'b1, "d4_e2");
    edge_then(341, 1'b1, 3'd1, 1'b1, 1'b1, "d4_e3");
    edge_then(100, 1'b1, 3'd1, 1'b0, 1'b1, "d4_e4");
    #2 RESET = 1'b1;
    #1;
    compared++;
    if ({bus.NOTE, bus.NOTE_OH, bus.NOTE_VALID, bus.NEW_NOTE, bus.PERIOD} !== '0) begin
      mismatched++;
      $display("FAIL async reset outputs: got note=%0d oh=%b v=%b p=%0d want all 0",
               bus.NOTE, bus.NOTE_OH, bus.NOTE_VALID, bus.PERIOD);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    edge_then(341, 1'b0, 3'd0, 1'b0, 1'b0, "d4_r1");
    edge_then(341, 1'b0, 3'd0, 1'b0, 1'b1, "d4_r2");
    edge_then(341, 1'b1, 3'd1, 1'b1, 1'b1, "d4_r3");
    edge_then(20,  1'b1, 3'd1, 1'b0, 1'b1, "d4_r4");
    check_pulses(p0, 2, "reset_mid");
  endtask

  initial begin
    bus.FREQ_IN = 1'b0;
    test_reset();
    test_steady_a4();
    test_note_change();
    test_glitch();
    test_silence();
    test_reset_mid();
    repeat (10) @(negedge CLK);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
